// File: rtl/accum_pkg.sv
// Shared state encoding and default widths for the accumulator scheduler.
package accum_pkg;
   typedef enum logic [2:0] {IDLE, CLR, ACCUM, DRAIN, RESULT} state_t;

   localparam int DEF_N_REQ = 2;
   localparam int DEF_IN_W  = 4;
   localparam int DEF_ACC_W = 16;
   localparam int DEF_LEN_W = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr, wrapping.
module rr_arbiter
   import accum_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDW   = $clog2(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   id,
   output logic             any
);
   always_comb begin
      int idx;
      idx = 0;
      gnt = '0;
      id  = '0;
      any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            id       = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one external accumulator among N_REQ requesters;
// drives the datapath clear/load controls and returns each job's sum on a result handshake.
module accum_sched
   import accum_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IN_W  = DEF_IN_W,
   parameter int ACC_W = DEF_ACC_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic                     clk,
   input  logic                     Rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*LEN_W-1:0]   req_len,
   input  logic [N_REQ-1:0]         in_valid,
   input  logic [N_REQ*IN_W-1:0]    in_data,
   output logic [N_REQ-1:0]         in_ready,
   output logic [N_REQ-1:0]         grant,
   output logic                     acc_clr,
   output logic                     acc_load,
   output logic [IN_W-1:0]          acc_ln,
   input  logic [ACC_W-1:0]         acc_out,
   output logic                     res_valid,
   output logic [ACC_W-1:0]         res_data,
   output logic [$clog2(N_REQ)-1:0] res_id,
   output logic                     res_ovf,
   input  logic                     res_ready
);
   localparam int IDW = $clog2(N_REQ);

   state_t           state, nxt;
   logic [IDW-1:0]   owner, rr_ptr, arb_id, ptr_nxt;
   logic [N_REQ-1:0] arb_gnt;
   logic             arb_any;
   logic [LEN_W-1:0] cnt, arb_len;
   logic             ovf, xfer;
   logic [IN_W-1:0]  op;

   // Carry out of the datapath add at ACC_W bits, i.e. the sum wrapped this transfer.
   function automatic logic carry_out(input logic [ACC_W-1:0] a, input logic [IN_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
      return s[ACC_W];
   endfunction

   rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .id  (arb_id),
      .any (arb_any)
   );

   assign ptr_nxt = (owner == IDW'(N_REQ - 1)) ? '0 : owner + IDW'(1);

   always_comb begin
      op       = '0;
      arb_len  = '0;
      in_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDW'(i) == owner) begin
            op          = in_data[i*IN_W +: IN_W];
            in_ready[i] = (state == ACCUM);
         end
         if (IDW'(i) == arb_id) arb_len = req_len[i*LEN_W +: LEN_W];
      end
      xfer      = |(in_valid & in_ready);
      acc_load  = xfer;
      acc_ln    = xfer ? op : '0;
      acc_clr   = (state == CLR);
      res_valid = (state == RESULT);
      nxt       = state;
      case (state)
         IDLE:    if (arb_any) nxt = CLR;
         CLR:     nxt = (cnt == '0) ? DRAIN : ACCUM;
         ACCUM:   if (xfer && cnt == LEN_W'(1)) nxt = DRAIN;
         DRAIN:   nxt = RESULT;
         RESULT:  if (res_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         grant    <= '0;
         res_data <= '0;
         res_id   <= '0;
         res_ovf  <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (arb_any) begin
               owner <= arb_id;
               cnt   <= arb_len;
               grant <= arb_gnt;
            end
            CLR: ovf <= 1'b0;
            ACCUM: if (xfer) begin
               cnt <= cnt - LEN_W'(1);
               ovf <= ovf | carry_out(acc_out, acc_ln);
            end
            // Register has absorbed the last load by now; snapshot the result.
            DRAIN: begin
               res_data <= acc_out;
               res_ovf  <= ovf;
               res_id   <= owner;
            end
            RESULT: if (res_ready) begin
               rr_ptr <= ptr_nxt;
               grant  <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule
